// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter (ALU / load path) in front of a single register-file write port.
// Define REGARB_FIXED_PRIO_EN for fixed ALU-first priority; default build is round-robin.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  AluValid,
  input  logic [ADDR_WIDTH-1:0] AluReg,
  input  logic [DATA_WIDTH-1:0] AluData,
  output logic                  AluReady,
  input  logic                  MemValid,
  input  logic [ADDR_WIDTH-1:0] MemReg,
  input  logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemReady,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite,
  output logic                  Idle
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // Index 0 is the ALU requester, index 1 the memory requester.
  logic [ADDR_WIDTH-1:0] in_reg   [2];
  logic [DATA_WIDTH-1:0] in_data  [2];
  logic [ADDR_WIDTH-1:0] fifo_reg_q  [2][DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [2][DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [2];
  logic [PTR_W-1:0]      rd_ptr_q [2];
  logic [CNT_W-1:0]      count_q  [2];
  logic [CNT_W-1:0]      count_d  [2];
  logic [1:0]            ready_q, ready_d;
  logic [1:0]            push, pop, nonempty;

  logic                  grant_valid;
  grant_e                grant_sel;
  logic [ADDR_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] head_data;

  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  regwrite_q, regwrite_d;

  assign in_reg[0]  = AluReg;
  assign in_reg[1]  = MemReg;
  assign in_data[0] = AluData;
  assign in_data[1] = MemData;

  assign push = {MemValid, AluValid} & ready_q;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      nonempty[i] = (count_q[i] != '0);
      count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      ready_d[i]  = (count_d[i] < CNT_W'(DEPTH));
    end
  end

`ifndef REGARB_FIXED_PRIO_EN
  grant_e last_q, last_d;

  always_comb begin
    last_d = grant_valid ? grant_sel : last_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) last_q <= GRANT_MEM;
    else        last_q <= last_d;
  end
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = GRANT_ALU;
`ifdef REGARB_FIXED_PRIO_EN
    if (nonempty[0]) begin
      grant_valid = 1'b1;
      grant_sel   = GRANT_ALU;
    end else if (nonempty[1]) begin
      grant_valid = 1'b1;
      grant_sel   = GRANT_MEM;
    end
`else
    if (nonempty[0] && nonempty[1]) begin
      grant_valid = 1'b1;
      grant_sel   = (last_q == GRANT_MEM) ? GRANT_ALU : GRANT_MEM;
    end else if (nonempty[0]) begin
      grant_valid = 1'b1;
      grant_sel   = GRANT_ALU;
    end else if (nonempty[1]) begin
      grant_valid = 1'b1;
      grant_sel   = GRANT_MEM;
    end
`endif
  end

  always_comb begin
    pop       = '0;
    head_reg  = fifo_reg_q[0][rd_ptr_q[0]];
    head_data = fifo_data_q[0][rd_ptr_q[0]];
    if (grant_sel == GRANT_MEM) begin
      head_reg  = fifo_reg_q[1][rd_ptr_q[1]];
      head_data = fifo_data_q[1][rd_ptr_q[1]];
    end
    if (grant_valid) pop = (grant_sel == GRANT_MEM) ? 2'b10 : 2'b01;
  end

  // Address/data hold between grants; only the strobe falls back to 0.
  always_comb begin
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    regwrite_d = 1'b0;
    if (grant_valid) begin
      wreg_d     = head_reg;
      wdata_d    = head_data;
      regwrite_d = (head_reg != '0);
    end
  end

  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) begin
        fifo_reg_q[i][wr_ptr_q[i]]  <= in_reg[i];
        fifo_data_q[i][wr_ptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ready_q    <= '0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        count_q[i] <= count_d[i];
      end
      ready_q    <= ready_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign AluReady      = ready_q[0];
  assign MemReady      = ready_q[1];
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign RegWrite      = regwrite_q;
  assign Idle          = (count_q[0] == '0) && (count_q[1] == '0) && !regwrite_q;

endmodule
